cpu_instr_sequencer: RTL and testbench
======================================

// Module: cpu_instr_sequencer
// PURPOSE
//  Program sequencer for simple_cpu. Holds a small writable program memory of
//  20-bit instructions and, on start, resets the CPU. It then issues each
//  instruction on the CPU instruction port for a fixed number of cycles.
//  Replaces hand-driven instruction streams; sits between host/test logic and simple_cpu.
// PARAMETERS
//  INSTR_WIDTH      20  instruction width (matches simple_cpu)
//  PROG_DEPTH_BITS  4   log2 program memory depth (16 entries)
//  HOLD_CYCLES      4   cycles each instruction is presented to the CPU (>=1)
// PORTS
//  clk          in   1                  clock, all logic on rising edge
//  rst          in   1                  synchronous reset, active high
//  prog_we      in   1                  program memory write strobe
//  prog_addr    in   PROG_DEPTH_BITS    write address
//  prog_wdata   in   INSTR_WIDTH        write data
//  start        in   1                  one-cycle run request
//  prog_len     in   PROG_DEPTH_BITS+1  number of instructions to run; latched on start
//  abort        in   1                  stop the run, return to IDLE
//  loop         in   1                  restart at end (used only with SEQ_LOOP_EN)
//  instruction  out  INSTR_WIDTH        registered instruction to simple_cpu
//  cpu_rst      out  1                  registered reset to simple_cpu
//  pc           out  PROG_DEPTH_BITS    index of the instruction being issued
//  busy         out  1                  high in CPU_RST and RUN
//  done         out  1                  high in DONE
// BEHAVIOUR
//  - Reset values: instruction=0, cpu_rst=1, pc=0, busy=0, done=0, state=IDLE, hold_cnt=0.
//    Program memory contents are not reset.
//  - States: IDLE, CPU_RST, RUN, DONE. cpu_rst=1 only under rst and in CPU_RST.
//  - IDLE/DONE + start, len=0: go to DONE (or stay in DONE). No CPU reset.
//  - IDLE/DONE + start, len!=0: latch len, clamped to 2^PROG_DEPTH_BITS. Set pc=0.
//    Enter CPU_RST for exactly 2 cycles.
//  - Timing: start sampled at edge N -> cpu_rst=1 after edges N+1 and N+2.
//    After edge N+3: cpu_rst=0 and instruction=mem[0].
//  - RUN: each instruction is held for HOLD_CYCLES cycles; hold_cnt counts 0..HOLD_CYCLES-1.
//    At the last count, if pc==len-1: enter DONE. Otherwise pc+1 and load instruction=mem[pc+1].
//    The next instruction follows with no gap.
//  - DONE: instruction and pc hold their last values; done=1; busy=0.
//    done clears on the next start or on rst.
//  - abort has priority over all other inputs in every state. Next cycle: IDLE,
//    instruction=0, cpu_rst=0, pc=0, busy=0, done=0.
//  - start while busy: ignored. start and abort in the same cycle: abort wins.
//  - prog_we while busy: write dropped. prog_we in IDLE/DONE: written.
//    A write in the same cycle as start is visible to that run.
//  - pc never wraps. Run length is bounded by the clamped len.
//  - rst mid-run: immediate return to reset values, cpu_rst=1.
// CONFIGURATION
//  SEQ_LOOP_EN defined: in RUN, at the last hold cycle of pc==len-1 with loop=1,
//    set pc=0 and instruction=mem[0] and stay in RUN. No CPU reset; done stays 0.
//    With loop=0, enter DONE as normal.
//  SEQ_LOOP_EN undefined: loop input is ignored and unused; the run always ends in DONE.
// TESTING
//  1 rst=1 for 2 cycles -> instruction=0, cpu_rst=1, busy=0, done=0, pc=0.
//  2 Write 0x47000, 0x53000, 0x72001 at 0..2; prog_len=3; start at edge N ->
//    cpu_rst=1 for 2 cycles.
//    Then 0x47000 for edges N+3..N+6, 0x53000 for N+7..N+10, 0x72001 for N+11..N+14.
//    done=1 from N+15, pc=2, instruction stays 0x72001. simple_cpu regs become r0=4, r1=7, r3=2.
//  3 start with prog_len=0 from IDLE -> done=1 next cycle, cpu_rst stays 0, busy stays 0.
//  4 Run as in 2; abort on the 2nd cycle of 0x53000 -> next cycle IDLE, instruction=0, pc=0, busy=0.
//  5 During a run, prog_we writes 0xD80F0 to addr 0 and start pulses -> both ignored.
//    Mem[0] reads 0x47000 on the next run.
//  6 SEQ_LOOP_EN, loop=1, prog_len=2 -> 0x47000, 0x53000, then 0x47000 again with no gap.
//    cpu_rst=0, done=0. Drop loop -> DONE after the next 0x53000 slot.

Source files
------------

// File: rtl/cpu_instr_sequencer.sv
// Program sequencer for simple_cpu: writable 16x20b program memory and a cpu_rst plus instruction issue FSM; loop-at-end is built only with SEQ_LOOP_EN.
// Latency: start sampled at edge N gives cpu_rst after N+1 and N+2, then mem[0] after N+3; each instruction is held HOLD_CYCLES cycles.
// No backpressure: start and prog_we are dropped while a run is active, and abort or rst clears the outputs on the next edge.
module cpu_instr_sequencer #(
    parameter int INSTR_WIDTH     = 20,
    parameter int PROG_DEPTH_BITS = 4,
    parameter int HOLD_CYCLES     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prog_we,
    input  logic [PROG_DEPTH_BITS-1:0] prog_addr,
    input  logic [INSTR_WIDTH-1:0]     prog_wdata,
    input  logic                       start,
    input  logic [PROG_DEPTH_BITS:0]   prog_len,
    input  logic                       abort,
    input  logic                       loop,
    output logic [INSTR_WIDTH-1:0]     instruction,
    output logic                       cpu_rst,
    output logic [PROG_DEPTH_BITS-1:0] pc,
    output logic                       busy,
    output logic                       done
);
    localparam int DEPTH = 1 << PROG_DEPTH_BITS;
    localparam int HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int LW    = PROG_DEPTH_BITS + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0] LEN_MAX   = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, CPU_RST, RUN, DONE} state_t;

    state_t                     state, state_n;
    logic [PROG_DEPTH_BITS-1:0] pc_q, pc_n;
    logic [HW-1:0]              hold_cnt, hold_n;
    logic                       rst_cnt, rst_cnt_n;
    logic [LW-1:0]              len_q, len_n;
    logic [INSTR_WIDTH-1:0]     mem [DEPTH];

    logic [INSTR_WIDTH-1:0]     instr_d;
    logic [PROG_DEPTH_BITS-1:0] pc_d;
    logic                       cpu_rst_d, busy_d, done_d;
    logic                       idle_like, last_slot, at_end, loop_en;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign last_slot = (hold_cnt == HOLD_LAST);
    assign at_end    = ({1'b0, pc_q} == (len_q - LW'(1)));

`ifdef SEQ_LOOP_EN
    assign loop_en = loop;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign loop_en     = 1'b0;
`endif

    // Program memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (prog_we && idle_like && !abort) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc_q        <= '0;
            hold_cnt    <= '0;
            rst_cnt     <= 1'b0;
            len_q       <= '0;
            instruction <= '0;
            cpu_rst     <= 1'b1;
            pc          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            pc_q        <= pc_n;
            hold_cnt    <= hold_n;
            rst_cnt     <= rst_cnt_n;
            len_q       <= len_n;
            instruction <= instr_d;
            cpu_rst     <= cpu_rst_d;
            pc          <= pc_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc_q;
        hold_n    = hold_cnt;
        rst_cnt_n = rst_cnt;
        len_n     = len_q;
        if (abort) begin
            state_n   = IDLE;
            pc_n      = '0;
            hold_n    = '0;
            rst_cnt_n = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (prog_len == '0) begin
                            state_n = DONE;
                        end else begin
                            state_n   = CPU_RST;
                            len_n     = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
                            pc_n      = '0;
                            hold_n    = '0;
                            rst_cnt_n = 1'b0;
                        end
                    end
                end
                CPU_RST: begin
                    if (rst_cnt) begin
                        state_n   = RUN;
                        rst_cnt_n = 1'b0;
                        hold_n    = '0;
                    end else begin
                        rst_cnt_n = 1'b1;
                    end
                end
                RUN: begin
                    if (last_slot) begin
                        hold_n = '0;
                        if (at_end) begin
                            if (loop_en) begin
                                pc_n = '0;
                            end else begin
                                state_n = DONE;
                            end
                        end else begin
                            pc_n = pc_q + 1'b1;
                        end
                    end else begin
                        hold_n = hold_cnt + HW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs trail the internal state by one register stage; abort clears them directly.
    always_comb begin
        instr_d   = '0;
        cpu_rst_d = 1'b0;
        pc_d      = pc_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        if (abort) begin
            pc_d = '0;
        end else begin
            case (state)
                CPU_RST: begin
                    cpu_rst_d = 1'b1;
                    busy_d    = 1'b1;
                end
                RUN: begin
                    instr_d = mem[pc_q];
                    busy_d  = 1'b1;
                end
                DONE: begin
                    instr_d = instruction;
                    done_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Bench for cpu_instr_sequencer: reset/idle vector table, directed run, abort, write-while-busy and loop sequences, then random runs against a slot-arithmetic model.
module tb_cpu_instr_sequencer;
    localparam int IW    = 20;
    localparam int PB    = 4;
    localparam int LW    = PB + 1;
    localparam int H     = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst, prog_we, start, abort, loop;
    logic [PB-1:0] prog_addr;
    logic [IW-1:0] prog_wdata;
    logic [LW-1:0] prog_len;
    logic [IW-1:0] instruction;
    logic          cpu_rst, busy, done;
    logic [PB-1:0] pc;

    always #5 clk = ~clk;

    cpu_instr_sequencer #(.INSTR_WIDTH(IW), .PROG_DEPTH_BITS(PB), .HOLD_CYCLES(H)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .start(start), .prog_len(prog_len), .abort(abort), .loop(loop),
        .instruction(instruction), .cpu_rst(cpu_rst), .pc(pc), .busy(busy), .done(done)
    );

    typedef struct {
        logic [IW-1:0] instr;
        logic          cpu_rst;
        logic [PB-1:0] pc;
        logic          busy;
        logic          done;
    } outs_t;

    typedef struct {
        string         name;
        logic          rst;
        logic          we;
        logic [PB-1:0] addr;
        logic [IW-1:0] wdata;
        logic          start;
        logic [LW-1:0] len;
        logic          abort;
        outs_t         exp;
    } vec_t;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [IW-1:0] mmem [DEPTH];
    logic [IW-1:0] last_instr;
    logic [PB-1:0] last_pc;
    vec_t          vecs [12];

    function automatic outs_t mk(input logic [IW-1:0] i, input logic r, input int p, input logic b, input logic d);
        outs_t o;
        o.instr = i; o.cpu_rst = r; o.pc = PB'(p); o.busy = b; o.done = d;
        return o;
    endfunction

    function automatic vec_t mkv(input string n, input logic r, input logic we, input int a, input logic [IW-1:0] wd,
                                 input logic s, input int len, input logic ab, input outs_t e);
        vec_t v;
        v.name = n; v.rst = r; v.we = we; v.addr = PB'(a); v.wdata = wd;
        v.start = s; v.len = LW'(len); v.abort = ab; v.exp = e;
        return v;
    endfunction

    // Expected outputs k edges after the start edge: two reset cycles, then L slots of H cycles, then DONE.
    function automatic outs_t run_exp(input int k, input int L);
        int slot;
        if (k <= 2) return mk('0, 1'b1, 0, 1'b1, 1'b0);
        slot = (k - 3) / H;
        if (slot < L) return mk(mmem[slot], 1'b0, slot, 1'b1, 1'b0);
        return mk(mmem[L-1], 1'b0, L - 1, 1'b0, 1'b1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; prog_we = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    task automatic check(input string nm, input outs_t e);
        n_chk++;
        if (instruction !== e.instr || cpu_rst !== e.cpu_rst || pc !== e.pc || busy !== e.busy || done !== e.done) begin
            n_fail++;
            $display("FAIL %s: got instr=%05h cpu_rst=%0b pc=%0d busy=%0b done=%0b, expected instr=%05h cpu_rst=%0b pc=%0d busy=%0b done=%0b",
                     nm, instruction, cpu_rst, pc, busy, done, e.instr, e.cpu_rst, e.pc, e.busy, e.done);
        end
    endtask

    // Start a run of len_in; abort before edge abort_at (0 = never); noise drives ignored start/prog_we while busy.
    task automatic run_checked(input int len_in, input string nm, input int abort_at, input bit noise);
        int L;
        L = (len_in > DEPTH) ? DEPTH : len_in;
        prog_len = LW'(len_in);
        start    = 1'b1;
        tick();
        clear_inputs();
        if (L == 0) begin
            tick();
            check({nm, "_len0"}, mk(last_instr, 1'b0, int'(last_pc), 1'b0, 1'b1));
            return;
        end
        for (int k = 1; k <= 3 + L * H; k++) begin
            if (k == abort_at) begin
                abort = 1'b1;
            end else if (noise && k <= 2 + L * H && $urandom_range(0, 3) == 0) begin
                start      = 1'b1;
                prog_len   = LW'($urandom_range(0, 20));
                prog_we    = 1'b1;
                prog_addr  = PB'($urandom_range(0, DEPTH - 1));
                prog_wdata = IW'($urandom);
            end
            tick();
            clear_inputs();
            if (k == abort_at) begin
                check({nm, "_abort"}, mk('0, 1'b0, 0, 1'b0, 1'b0));
                last_instr = '0;
                last_pc    = '0;
                return;
            end
            check($sformatf("%s_k%0d", nm, k), run_exp(k, L));
        end
        last_instr = mmem[L-1];
        last_pc    = PB'(L - 1);
    endtask

    initial begin
        outs_t z, r1;
        rst = 1'b1; prog_we = 1'b0; start = 1'b0; abort = 1'b0; loop = 1'b0;
        prog_addr = '0; prog_wdata = '0; prog_len = '0;
        z  = mk('0, 1'b0, 0, 1'b0, 1'b0);
        r1 = mk('0, 1'b1, 0, 1'b0, 1'b0);

        vecs[0]  = mkv("rst0",       1, 0, 0, 20'h0,     0, 0, 0, r1);
        vecs[1]  = mkv("rst1",       1, 0, 0, 20'h0,     0, 0, 0, r1);
        vecs[2]  = mkv("idle",       0, 0, 0, 20'h0,     0, 0, 0, z);
        vecs[3]  = mkv("wr0",        0, 1, 0, 20'h47000, 0, 0, 0, z);
        vecs[4]  = mkv("wr1",        0, 1, 1, 20'h53000, 0, 0, 0, z);
        vecs[5]  = mkv("wr2",        0, 1, 2, 20'h72001, 0, 0, 0, z);
        vecs[6]  = mkv("len0_start", 0, 0, 0, 20'h0,     1, 0, 0, z);
        vecs[7]  = mkv("len0_done",  0, 0, 0, 20'h0,     0, 0, 0, mk('0, 1'b0, 0, 1'b0, 1'b1));
        vecs[8]  = mkv("len0_again", 0, 0, 0, 20'h0,     1, 0, 0, mk('0, 1'b0, 0, 1'b0, 1'b1));
        vecs[9]  = mkv("len0_hold",  0, 0, 0, 20'h0,     0, 0, 0, mk('0, 1'b0, 0, 1'b0, 1'b1));
        vecs[10] = mkv("abort_wins", 0, 0, 0, 20'h0,     1, 3, 1, z);
        vecs[11] = mkv("abort_idle", 0, 0, 0, 20'h0,     0, 0, 0, z);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; prog_we = vecs[i].we; prog_addr = vecs[i].addr;
            prog_wdata = vecs[i].wdata; start = vecs[i].start; prog_len = vecs[i].len; abort = vecs[i].abort;
            if (vecs[i].we) mmem[vecs[i].addr] = vecs[i].wdata;
            tick();
            clear_inputs();
            check(vecs[i].name, vecs[i].exp);
        end
        last_instr = '0;
        last_pc    = '0;

        run_checked(3, "prog3", 0, 1'b0);
        run_checked(3, "abort53", 9, 1'b0);

        // Write and start while busy must both be dropped.
        prog_len = LW'(3);
        start    = 1'b1;
        tick();
        clear_inputs();
        for (int k = 1; k <= 15; k++) begin
            if (k == 5) begin
                prog_we = 1'b1; prog_addr = '0; prog_wdata = 20'hD80F0; start = 1'b1; prog_len = LW'(1);
            end
            tick();
            clear_inputs();
            check($sformatf("busy_wr_k%0d", k), run_exp(k, 3));
        end
        last_instr = mmem[2];
        last_pc    = PB'(2);
        run_checked(1, "after_drop", 0, 1'b0);

`ifdef SEQ_LOOP_EN
        loop     = 1'b1;
        prog_len = LW'(2);
        start    = 1'b1;
        tick();
        clear_inputs();
        for (int k = 1; k <= 19; k++) begin
            outs_t e;
            if (k == 12) loop = 1'b0;
            tick();
            if (k <= 2)       e = run_exp(k, 2);
            else if (k < 19)  e = mk(mmem[((k - 3) / H) % 2], 1'b0, ((k - 3) / H) % 2, 1'b1, 1'b0);
            else              e = mk(mmem[1], 1'b0, 1, 1'b0, 1'b1);
            check($sformatf("loop_k%0d", k), e);
        end
        last_instr = mmem[1];
        last_pc    = PB'(1);
`else
        loop = 1'b1;
        run_checked(2, "loop_ignored", 0, 1'b0);
        loop = 1'b0;
`endif

        // Synchronous reset in the middle of a run.
        prog_len = LW'(3);
        start    = 1'b1;
        tick();
        clear_inputs();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("rst_midrun", r1);
        rst = 1'b0;
        tick();
        check("rst_release", z);
        last_instr = '0;
        last_pc    = '0;

        for (int r = 0; r < 25; r++) begin
            int len, L, ab;
            repeat ($urandom_range(0, 3)) begin
                prog_we    = 1'b1;
                prog_addr  = PB'($urandom_range(0, DEPTH - 1));
                prog_wdata = IW'($urandom);
                mmem[prog_addr] = prog_wdata;
                tick();
                clear_inputs();
            end
            len = $urandom_range(0, 20);
            L   = (len > DEPTH) ? DEPTH : len;
            ab  = (L > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 2 + L * H) : 0;
            prog_we    = 1'b1;
            prog_addr  = PB'($urandom_range(0, DEPTH - 1));
            prog_wdata = IW'($urandom);
            mmem[prog_addr] = prog_wdata;
            run_checked(len, $sformatf("rnd%0d", r), ab, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
